core_sequencer: RTL and testbench

Multi-cycle control FSM for the 16-bit core. It owns the program counter and fetches instructions over a req/ack handshake to instruction ROM. It decodes opcode/src/dst/funct and steps each instruction through FETCH, DECODE, EXEC and WB, driving register-file addresses and write enable, ALU op/source/immediate, and branch/jump PC updates. It sits between pc/rom and register_file/alu, replacing the single-cycle control_unit path.

---
 rtl/core_sequencer.sv | 155 +++++++++++++++
 tb/tb_core_sequencer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/core_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/WB sequencer for the 16-bit core.
// Owns the PC, fetches over req/ack and drives register-file and ALU controls.
module core_sequencer #(
    parameter int PC_W    = 8,
    parameter int DATA_W  = 16,
    parameter int RADDR_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               run,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ack,
    input  logic [15:0]        imem_rdata,
    output logic [RADDR_W-1:0] rf_r1_addr,
    output logic [RADDR_W-1:0] rf_r2_addr,
    output logic [RADDR_W-1:0] rf_wr_addr,
    output logic               rf_wr_en,
    output logic [2:0]         alu_op,
    output logic               alu_src,
    output logic [DATA_W-1:0]  imm,
    input  logic               alu_zero,
    output logic [PC_W-1:0]    pc,
    output logic               busy,
    output logic               halted,
    output logic               illegal,
    output logic [15:0]        retired
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_WB,
        S_HALT
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [PC_W-1:0]   r_pc;
    logic [15:0]       r_ir;
    logic [15:0]       r_retired;
    logic              r_illegal;
    logic              r_take_br;

    logic [2:0]        w_opc;
    logic              w_is_r;
    logic              w_is_addi;
    logic              w_is_beqz;
    logic              w_is_jmp;
    logic              w_is_halt;
    logic              w_is_ill;
    logic              w_in_dx;
    logic [PC_W-1:0]   w_pc_inc;
    logic [PC_W-1:0]   w_pc_off;
    logic [PC_W-1:0]   w_pc_wb;

    assign w_opc     = r_ir[15:13];
    assign w_is_r    = (w_opc == 3'b000);
    assign w_is_addi = (w_opc == 3'b001);
    assign w_is_beqz = (w_opc == 3'b010);
    assign w_is_jmp  = (w_opc == 3'b011);
    assign w_is_halt = (w_opc == 3'b111);
    assign w_is_ill  = w_opc[2] & ~w_is_halt;

    assign w_pc_inc = r_pc + PC_W'(1);
    assign w_pc_off = r_pc + {{(PC_W-5){r_ir[12]}}, r_ir[12:8]};

    always_comb begin
        w_pc_wb = w_pc_inc;
        if (w_is_beqz && r_take_br)
            w_pc_wb = w_pc_off;
        else if (w_is_jmp)
            w_pc_wb = r_ir[PC_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_pc      <= '0;
            r_ir      <= '0;
            r_retired <= '0;
            r_illegal <= 1'b0;
            r_take_br <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == S_FETCH && imem_ack)
                r_ir <= imem_rdata;
            if (r_state == S_DECODE && w_is_ill) begin
                r_illegal <= 1'b1;
                r_pc      <= w_pc_inc;
            end
            if (r_state == S_EXEC)
                r_take_br <= w_is_beqz & alu_zero;
            if (r_state == S_WB) begin
                r_pc      <= w_pc_wb;
                r_retired <= r_retired + 16'd1;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:   if (run) w_next = S_FETCH;
            S_FETCH:  if (imem_ack) w_next = S_DECODE;
            S_DECODE: begin
                if (w_is_halt)
                    w_next = S_HALT;
                else if (w_is_ill)
                    w_next = S_FETCH;
                else
                    w_next = S_EXEC;
            end
            S_EXEC:   w_next = S_WB;
            S_WB:     w_next = S_FETCH;
            S_HALT:   w_next = S_HALT;
            default:  w_next = S_IDLE;
        endcase
    end

    assign w_in_dx = (r_state == S_DECODE) || (r_state == S_EXEC)
                  || (r_state == S_WB);

    always_comb begin
        alu_op  = 3'b000;
        alu_src = 1'b0;
        imm     = '0;
        if (w_in_dx) begin
            unique case (1'b1)
                w_is_r:    alu_op = r_ir[2:0];
                w_is_addi: begin
                    alu_src = 1'b1;
                    imm     = {{(DATA_W-5){1'b0}}, r_ir[12:8]};
                end
                w_is_beqz: alu_src = 1'b1;
                default: ;
            endcase
        end
    end

    assign imem_req   = (r_state == S_FETCH);
    assign imem_addr  = r_pc;
    assign rf_r1_addr = r_ir[12:8];
    assign rf_r2_addr = r_ir[7:3];
    assign rf_wr_addr = r_ir[7:3];
    assign rf_wr_en   = (r_state == S_WB) && (w_is_r || w_is_addi);
    assign pc         = r_pc;
    assign busy       = (r_state != S_IDLE) && (r_state != S_HALT);
    assign halted     = (r_state == S_HALT);
    assign illegal    = r_illegal;
    assign retired    = r_retired;

endmodule

// File: tb/tb_core_sequencer.sv
// Directed bench for core_sequencer: per-instruction vector table
// plus hand-written illegal/HALT and reset-during-fetch sequences.
module tb_core_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        run;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic [4:0]  rf_r1_addr;
    logic [4:0]  rf_r2_addr;
    logic [4:0]  rf_wr_addr;
    logic        rf_wr_en;
    logic [2:0]  alu_op;
    logic        alu_src;
    logic [15:0] imm;
    logic        alu_zero;
    logic [7:0]  pc;
    logic        busy;
    logic        halted;
    logic        illegal;
    logic [15:0] retired;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    core_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .run       (run),
        .imem_req  (imem_req),
        .imem_addr (imem_addr),
        .imem_ack  (imem_ack),
        .imem_rdata(imem_rdata),
        .rf_r1_addr(rf_r1_addr),
        .rf_r2_addr(rf_r2_addr),
        .rf_wr_addr(rf_wr_addr),
        .rf_wr_en  (rf_wr_en),
        .alu_op    (alu_op),
        .alu_src   (alu_src),
        .imm       (imm),
        .alu_zero  (alu_zero),
        .pc        (pc),
        .busy      (busy),
        .halted    (halted),
        .illegal   (illegal),
        .retired   (retired)
    );

    typedef struct {
        logic [15:0] instr;
        logic [7:0]  pc0;
        int          waitc;
        logic        zero;
        logic [2:0]  op;
        logic        src;
        logic [15:0] imm;
        logic        wr;
        logic [4:0]  wa;
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic [7:0]  pc1;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic run_instr(input vec_t v, input int idx,
                             input logic [4:0] prev_r1);
        for (int w = 0; w < v.waitc; w++) begin
            @(negedge clk);
            run        = 1'b0;
            imem_ack   = 1'b0;
            imem_rdata = 16'hFFFF;
            chk($sformatf("v%0d wait%0d req", idx, w), imem_req, 1);
            chk($sformatf("v%0d wait%0d addr", idx, w), imem_addr, v.pc0);
            chk($sformatf("v%0d wait%0d r1", idx, w), rf_r1_addr, prev_r1);
            chk($sformatf("v%0d wait%0d wr", idx, w), rf_wr_en, 0);
        end
        @(negedge clk);
        run = 1'b0;
        chk($sformatf("v%0d fetch req", idx), imem_req, 1);
        chk($sformatf("v%0d fetch addr", idx), imem_addr, v.pc0);
        chk($sformatf("v%0d pc", idx), pc, v.pc0);
        chk($sformatf("v%0d retired", idx), retired, idx);
        chk($sformatf("v%0d fetch wr", idx), rf_wr_en, 0);
        chk($sformatf("v%0d fetch aluop", idx), alu_op, 0);
        imem_ack   = 1'b1;
        imem_rdata = v.instr;
        @(negedge clk);
        imem_ack   = 1'b0;
        imem_rdata = 16'h0000;
        chk($sformatf("v%0d dec req", idx), imem_req, 0);
        chk($sformatf("v%0d dec busy", idx), busy, 1);
        chk($sformatf("v%0d dec wr", idx), rf_wr_en, 0);
        chk($sformatf("v%0d r1", idx), rf_r1_addr, v.r1);
        chk($sformatf("v%0d r2", idx), rf_r2_addr, v.r2);
        @(negedge clk);
        alu_zero = v.zero;
        chk($sformatf("v%0d exec aluop", idx), alu_op, v.op);
        chk($sformatf("v%0d exec alusrc", idx), alu_src, v.src);
        chk($sformatf("v%0d exec imm", idx), imm, v.imm);
        chk($sformatf("v%0d exec wr", idx), rf_wr_en, 0);
        @(negedge clk);
        alu_zero = 1'b0;
        chk($sformatf("v%0d wb wr", idx), rf_wr_en, v.wr);
        if (v.wr)
            chk($sformatf("v%0d wb waddr", idx), rf_wr_addr, v.wa);
        chk($sformatf("v%0d wb r1 hold", idx), rf_r1_addr, v.r1);
    endtask

    initial begin
        // instr, pc0, wait, zero, op, src, imm, wr, wa, r1, r2, pc1
        vecs[0]  = '{16'h0111, 8'h00, 0, 1'b0, 3'd1, 1'b0, 16'h0000, 1'b1, 5'd2,  5'd1,  5'd2,  8'h01};
        vecs[1]  = '{16'h2710, 8'h01, 0, 1'b0, 3'd0, 1'b1, 16'h0007, 1'b1, 5'd2,  5'd7,  5'd2,  8'h02};
        vecs[2]  = '{16'h2108, 8'h02, 0, 1'b0, 3'd0, 1'b1, 16'h0001, 1'b1, 5'd1,  5'd1,  5'd1,  8'h03};
        vecs[3]  = '{16'h0000, 8'h03, 0, 1'b0, 3'd0, 1'b0, 16'h0000, 1'b1, 5'd0,  5'd0,  5'd0,  8'h04};
        vecs[4]  = '{16'h031A, 8'h04, 3, 1'b0, 3'd2, 1'b0, 16'h0000, 1'b1, 5'd3,  5'd3,  5'd3,  8'h05};
        vecs[5]  = '{16'h5E18, 8'h05, 0, 1'b1, 3'd0, 1'b1, 16'h0000, 1'b0, 5'd3,  5'd30, 5'd3,  8'h03};
        vecs[6]  = '{16'h5E18, 8'h03, 1, 1'b0, 3'd0, 1'b1, 16'h0000, 1'b0, 5'd3,  5'd30, 5'd3,  8'h04};
        vecs[7]  = '{16'h6005, 8'h04, 0, 1'b1, 3'd0, 1'b0, 16'h0000, 1'b0, 5'd0,  5'd0,  5'd0,  8'h05};
        vecs[8]  = '{16'h5E18, 8'h05, 0, 1'b0, 3'd0, 1'b1, 16'h0000, 1'b0, 5'd3,  5'd30, 5'd3,  8'h06};
        vecs[9]  = '{16'h60FF, 8'h06, 0, 1'b0, 3'd0, 1'b0, 16'h0000, 1'b0, 5'd31, 5'd0,  5'd31, 8'hFF};
        vecs[10] = '{16'h2710, 8'hFF, 0, 1'b0, 3'd0, 1'b1, 16'h0007, 1'b1, 5'd2,  5'd7,  5'd2,  8'h00};

        rst        = 1'b1;
        run        = 1'b0;
        imem_ack   = 1'b0;
        imem_rdata = 16'h0000;
        alu_zero   = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst req", imem_req, 0);
        chk("rst busy", busy, 0);
        chk("rst pc", pc, 0);
        chk("rst retired", retired, 0);
        chk("rst wr", rf_wr_en, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle busy", busy, 0);
        run = 1'b1;

        for (int i = 0; i < 11; i++)
            run_instr(vecs[i], i, (i == 0) ? 5'd0 : vecs[i-1].r1);

        // illegal opcode, then HALT
        @(negedge clk);
        chk("ill fetch addr", imem_addr, 8'h00);
        imem_ack   = 1'b1;
        imem_rdata = 16'h8000;
        @(negedge clk);
        imem_ack = 1'b0;
        chk("ill dec wr", rf_wr_en, 0);
        chk("ill dec flag", illegal, 0);
        @(negedge clk);
        chk("ill refetch req", imem_req, 1);
        chk("ill flag", illegal, 1);
        chk("ill pc", pc, 8'h01);
        chk("ill retired", retired, 11);
        chk("ill wr", rf_wr_en, 0);
        imem_ack   = 1'b1;
        imem_rdata = 16'hE000;
        @(negedge clk);
        imem_ack = 1'b0;
        chk("halt dec busy", busy, 1);
        @(negedge clk);
        chk("halt halted", halted, 1);
        chk("halt busy", busy, 0);
        chk("halt req", imem_req, 0);
        chk("halt ill sticky", illegal, 1);
        run = 1'b1;
        @(negedge clk);
        run = 1'b0;
        chk("halt run ign", halted, 1);
        chk("halt run req", imem_req, 0);
        chk("halt pc", pc, 8'h01);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst2 halted", halted, 0);
        chk("rst2 busy", busy, 0);
        chk("rst2 illegal", illegal, 0);
        chk("rst2 pc", pc, 0);
        chk("rst2 retired", retired, 0);
        chk("rst2 r1", rf_r1_addr, 0);

        // reset wins over an ack in the same cycle
        run = 1'b1;
        @(negedge clk);
        run = 1'b0;
        chk("rf fetch req", imem_req, 1);
        imem_ack   = 1'b1;
        imem_rdata = 16'h0111;
        rst        = 1'b1;
        @(negedge clk);
        rst      = 1'b0;
        imem_ack = 1'b0;
        chk("rf busy", busy, 0);
        chk("rf req", imem_req, 0);
        chk("rf pc", pc, 0);
        chk("rf ir r1", rf_r1_addr, 0);
        chk("rf ir r2", rf_r2_addr, 0);
        imem_ack = 1'b1;
        @(negedge clk);
        imem_ack = 1'b0;
        chk("late ack busy", busy, 0);
        chk("late ack req", imem_req, 0);
        chk("late ack r1", rf_r1_addr, 0);
        @(negedge clk);
        chk("late ack idle", busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
